// File: rtl/fc_layer.sv
// Fully-connected layer: buffers one pooled vector, then computes N_OUT saturated
// dot products serially and streams them out with valid/end markers.
module fc_layer #(
    parameter int IN_LEN = 36,
    parameter int N_OUT  = 10,
    parameter int N_DATA = 32,
    parameter int W_DATA = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   data_in_vld,
    input  logic signed [N_DATA-1:0]               data_in,
    input  logic                                   data_in_end,
    input  logic                                   wt_wr_en,
    input  logic [$clog2(N_OUT*IN_LEN+N_OUT)-1:0]  wt_wr_addr,
    input  logic signed [W_DATA-1:0]               wt_wr_data,
    output logic                                   busy,
    output logic signed [N_DATA-1:0]               data_out,
    output logic                                   data_out_vld,
    output logic                                   data_out_end,
    output logic                                   err_len
);
    // state  | meaning
    // S_LOAD | capturing input words into the x buffer; coefficient writes allowed
    // S_MAC  | issuing reads for every neuron, draining the MAC pipeline, emitting results

    localparam int WT_DEPTH = N_OUT*IN_LEN + N_OUT;
    localparam int AW       = $clog2(WT_DEPTH);
    localparam int IDX_W    = $clog2(IN_LEN);
    localparam int O_W      = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int PROD_W   = N_DATA + W_DATA;
    localparam int ACC_W    = PROD_W + $clog2(IN_LEN);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-N_DATA+1){1'b0}}, {(N_DATA-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-N_DATA+1){1'b1}}, {(N_DATA-1){1'b0}}};
    localparam logic [IDX_W-1:0]        IDX_LAST  = IDX_W'(IN_LEN-1);
    localparam logic [O_W-1:0]          O_LAST    = O_W'(N_OUT-1);
    localparam logic [AW-1:0]           BIAS_BASE = AW'(N_OUT*IN_LEN);

    typedef enum logic {S_LOAD, S_MAC} state_t;
    state_t state;

    logic signed [N_DATA-1:0] x_buf  [IN_LEN];
    logic signed [W_DATA-1:0] wt_ram [WT_DEPTH];

    logic [IDX_W-1:0]         count;
    logic [IDX_W-1:0]         idx;
    logic [O_W-1:0]           o_cnt;
    logic                     issuing;
    logic signed [N_DATA-1:0] x_rd;
    logic signed [W_DATA-1:0] w_rd;
    logic signed [W_DATA-1:0] b_rd;
    logic                     s1_vld, s1_first, s1_last, s1_end;
    logic signed [PROD_W-1:0] prod;
    logic                     s2_vld, s2_first, s2_last, s2_end;
    logic signed [ACC_W-1:0]  acc;
    logic                     s3_done, s3_end;

    logic [AW-1:0]            w_addr;
    logic                     load_word;
    logic                     short_end;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [N_DATA-1:0] sat_val;

    assign load_word = (state == S_LOAD) && data_in_vld;
    assign short_end = data_in_end && ((int'(count) + 1) < IN_LEN);
    assign w_addr    = AW'(o_cnt) * AW'(IN_LEN) + AW'(idx);
    assign bias_ext  = {{(ACC_W-W_DATA){b_rd[W_DATA-1]}}, b_rd};
    assign prod_ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign sat_val   = (acc > SAT_MAX) ? {1'b0, {(N_DATA-1){1'b1}}} :
                       (acc < SAT_MIN) ? {1'b1, {(N_DATA-1){1'b0}}} :
                                         acc[N_DATA-1:0];

    // Storage: coefficient RAM and input buffer keep their contents across reset.
    always_ff @(posedge clk) begin
        if (wt_wr_en && !busy && (32'(wt_wr_addr) < 32'(WT_DEPTH)))
            wt_ram[wt_wr_addr] <= wt_wr_data;
        if (!rst && load_word) begin
            for (int j = 0; j < IN_LEN; j++) begin
                if (j == int'(count))
                    x_buf[j] <= data_in;
                else if (data_in_end && j > int'(count))
                    x_buf[j] <= '0;
            end
        end
        if (issuing) begin
            x_rd <= x_buf[idx];
            w_rd <= wt_ram[w_addr];
            if (idx == '0)
                b_rd <= wt_ram[BIAS_BASE + AW'(o_cnt)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_LOAD;
            count        <= '0;
            idx          <= '0;
            o_cnt        <= '0;
            issuing      <= 1'b0;
            s1_vld       <= 1'b0;
            s1_first     <= 1'b0;
            s1_last      <= 1'b0;
            s1_end       <= 1'b0;
            s2_vld       <= 1'b0;
            s2_first     <= 1'b0;
            s2_last      <= 1'b0;
            s2_end       <= 1'b0;
            prod         <= '0;
            acc          <= '0;
            s3_done      <= 1'b0;
            s3_end       <= 1'b0;
            busy         <= 1'b0;
            data_out     <= '0;
            data_out_vld <= 1'b0;
            data_out_end <= 1'b0;
            err_len      <= 1'b0;
        end else begin
            err_len      <= 1'b0;
            data_out_vld <= 1'b0;
            data_out_end <= 1'b0;
            s1_vld       <= 1'b0;
            s3_done      <= 1'b0;

            case (state)
                S_LOAD: begin
                    if (load_word) begin
                        if (count == IDX_LAST || data_in_end) begin
                            err_len <= short_end;
                            count   <= '0;
                            idx     <= '0;
                            o_cnt   <= '0;
                            issuing <= 1'b1;
                            busy    <= 1'b1;
                            state   <= S_MAC;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    if (issuing) begin
                        s1_vld   <= 1'b1;
                        s1_first <= (idx == '0);
                        s1_last  <= (idx == IDX_LAST);
                        s1_end   <= (idx == IDX_LAST) && (o_cnt == O_LAST);
                        if (idx == IDX_LAST) begin
                            idx <= '0;
                            if (o_cnt == O_LAST)
                                issuing <= 1'b0;
                            else
                                o_cnt <= o_cnt + 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    // Leave one cycle after the final result before accepting input again.
                    if (data_out_vld && data_out_end) begin
                        busy  <= 1'b0;
                        state <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase

            s2_vld   <= s1_vld;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_end   <= s1_end;
            if (s1_vld)
                prod <= PROD_W'(x_rd) * PROD_W'(w_rd);

            if (s2_vld) begin
                acc     <= (s2_first ? bias_ext : acc) + prod_ext;
                s3_done <= s2_last;
                s3_end  <= s2_end;
            end

            if (s3_done) begin
                data_out     <= sat_val;
                data_out_vld <= 1'b1;
                data_out_end <= s3_end;
            end
        end
    end

endmodule

// File: tb/tb_fc_layer.sv
// Bench for fc_layer: a 4x2 instance driven with directed and random vectors against a
// plain dot-product model, plus a default-size 36x10 instance.
`timescale 1ns/1ps
module tb_fc_layer;
    localparam int IN_LEN = 4;
    localparam int N_OUT  = 2;
    localparam int DEPTH  = N_OUT*IN_LEN + N_OUT;
    localparam int AW     = $clog2(DEPTH);
    localparam int B_LEN  = 36;
    localparam int B_OUT  = 10;
    localparam int B_AW   = $clog2(B_OUT*B_LEN + B_OUT);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          s_vld = 1'b0, s_end = 1'b0, s_wen = 1'b0;
    logic [31:0]   s_din = '0;
    logic [AW-1:0] s_waddr = '0;
    logic [15:0]   s_wdata = '0;
    logic          s_busy, s_ovld, s_oend, s_err;
    logic [31:0]   s_dout;

    logic            b_vld = 1'b0, b_end = 1'b0, b_wen = 1'b0;
    logic [31:0]     b_din = '0;
    logic [B_AW-1:0] b_waddr = '0;
    logic [15:0]     b_wdata = '0;
    logic            b_busy, b_ovld, b_oend, b_err;
    logic [31:0]     b_dout;

    fc_layer #(.IN_LEN(IN_LEN), .N_OUT(N_OUT)) dut (
        .clk(clk), .rst(rst), .data_in_vld(s_vld), .data_in(s_din), .data_in_end(s_end),
        .wt_wr_en(s_wen), .wt_wr_addr(s_waddr), .wt_wr_data(s_wdata),
        .busy(s_busy), .data_out(s_dout), .data_out_vld(s_ovld), .data_out_end(s_oend),
        .err_len(s_err)
    );

    fc_layer dut_big (
        .clk(clk), .rst(rst), .data_in_vld(b_vld), .data_in(b_din), .data_in_end(b_end),
        .wt_wr_en(b_wen), .wt_wr_addr(b_waddr), .wt_wr_data(b_wdata),
        .busy(b_busy), .data_out(b_dout), .data_out_vld(b_ovld), .data_out_end(b_oend),
        .err_len(b_err)
    );

    int      n_vec = 0;
    int      n_err = 0;
    int      mx [IN_LEN];
    shortint mw [N_OUT][IN_LEN];
    shortint mb [N_OUT];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_y(input int o);
        longint acc = longint'(mb[o]);
        for (int i = 0; i < IN_LEN; i++)
            acc += longint'(mx[i]) * longint'(mw[o][i]);
        if (acc > 64'sd2147483647)
            return 32'h7FFF_FFFF;
        if (acc < -64'sd2147483648)
            return 32'h8000_0000;
        return 32'(acc);
    endfunction

    task automatic set_all_w(input shortint w, input shortint b);
        for (int o = 0; o < N_OUT; o++) begin
            mb[o] = b;
            for (int i = 0; i < IN_LEN; i++)
                mw[o][i] = w;
        end
    endtask

    // Writes the model coefficients, then junk to the unmapped addresses above the map.
    task automatic load_wts();
        for (int a = 0; a < (1 << AW); a++) begin
            s_wen   = 1'b1;
            s_waddr = AW'(a);
            if (a < N_OUT*IN_LEN)
                s_wdata = mw[a/IN_LEN][a%IN_LEN];
            else if (a < DEPTH)
                s_wdata = mb[a-N_OUT*IN_LEN];
            else
                s_wdata = 16'($urandom);
            @(posedge clk); #1;
        end
        s_wen = 1'b0;
    endtask

    task automatic run_vec(input int len, input bit use_end, input bit noise, input bit do_rst);
        logic [31:0] y [N_OUT];
        int n_seen = 0;
        int c_end  = -1;
        bit aborted = 1'b0;
        for (int i = len; i < IN_LEN; i++)
            mx[i] = 0;
        for (int o = 0; o < N_OUT; o++)
            y[o] = ref_y(o);
        for (int i = 0; i < len; i++) begin
            s_vld = 1'b1;
            s_din = mx[i];
            s_end = use_end && (i == len-1);
            @(posedge clk); #1;
        end
        s_vld = 1'b0;
        s_end = 1'b0;
        chk("err_len", s_err, (len < IN_LEN));
        chk("busy_start", s_busy, 1);
        for (int c = 1; c <= IN_LEN*N_OUT + 6; c++) begin
            if (noise) begin
                s_wen   = s_busy;
                s_waddr = AW'($urandom_range(0, DEPTH-1));
                s_wdata = 16'($urandom);
            end
            @(posedge clk); #1;
            if (c_end > 0 && c == c_end + 1)
                chk("busy_end", s_busy, 0);
            if (s_ovld) begin
                if (aborted || n_seen >= N_OUT) begin
                    chk("extra_vld", s_ovld, 0);
                end else begin
                    chk($sformatf("lat%0d", n_seen), c, IN_LEN + 3 + n_seen*IN_LEN);
                    chk($sformatf("y%0d", n_seen), s_dout, y[n_seen]);
                    chk($sformatf("end%0d", n_seen), s_oend, (n_seen == N_OUT-1));
                    if (n_seen == N_OUT-1) begin
                        c_end = c;
                        chk("busy_last", s_busy, 1);
                    end
                    n_seen++;
                    if (do_rst) begin
                        s_wen = 1'b0;
                        rst = 1'b1;
                        @(posedge clk); #1;
                        rst = 1'b0;
                        chk("rst_outs", {s_ovld, s_oend, s_busy, s_err, s_dout}, 0);
                        aborted = 1'b1;
                    end
                end
            end
        end
        s_wen = 1'b0;
        chk("n_results", n_seen, aborted ? 1 : N_OUT);
    endtask

    task automatic big_run(input bit noise);
        int n_seen = 0;
        for (int i = 0; i < B_LEN; i++) begin
            b_vld = 1'b1;
            b_din = 32'(i + 1);
            b_end = (i == B_LEN-1);
            @(posedge clk); #1;
        end
        b_vld = 1'b0;
        b_end = 1'b0;
        for (int c = 1; c <= B_LEN*B_OUT + 6; c++) begin
            if (noise) begin
                b_wen   = b_busy;
                b_waddr = B_AW'($urandom_range(0, B_OUT*B_LEN + B_OUT - 1));
                b_wdata = 16'($urandom);
            end
            @(posedge clk); #1;
            if (b_ovld) begin
                chk("big_lat", c, B_LEN + 3 + n_seen*B_LEN);
                chk("big_y", b_dout, 666);
                chk("big_end", b_oend, (n_seen == B_OUT-1));
                n_seen++;
            end
        end
        b_wen = 1'b0;
        chk("big_n", n_seen, B_OUT);
        chk("big_err", b_err, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_outs", {s_ovld, s_oend, s_busy, s_err, s_dout}, 0);

        // All-ones weights, with and without the end marker on the last word
        set_all_w(16'sd1, 16'sd0);
        mx = '{1, 2, 3, 4};
        load_wts();
        run_vec(IN_LEN, 1'b1, 1'b0, 1'b0);
        mx = '{1, 2, 3, 4};
        run_vec(IN_LEN, 1'b0, 1'b0, 1'b0);

        // Per-neuron weights and biases
        mw[0] = '{1, 2, 3, 4};
        mw[1] = '{-1, -1, -1, -1};
        mb    = '{5, -3};
        load_wts();
        mx = '{1, 2, 3, 4};
        run_vec(IN_LEN, 1'b1, 1'b0, 1'b0);

        // Positive and negative saturation
        set_all_w(16'sh7FFF, 16'sd0);
        load_wts();
        for (int i = 0; i < IN_LEN; i++) mx[i] = 32'h7FFF_FFFF;
        run_vec(IN_LEN, 1'b1, 1'b0, 1'b0);
        set_all_w(-16'sd32768, 16'sd0);
        load_wts();
        for (int i = 0; i < IN_LEN; i++) mx[i] = 32'h7FFF_FFFF;
        run_vec(IN_LEN, 1'b1, 1'b0, 1'b0);

        // Short vector: remaining buffer words must read as zero
        set_all_w(16'sd1, 16'sd0);
        load_wts();
        mx = '{1, 2, 0, 0};
        run_vec(2, 1'b1, 1'b0, 1'b0);

        // Reset between result pulses, then a clean vector
        mx = '{1, 2, 3, 4};
        run_vec(IN_LEN, 1'b1, 1'b0, 1'b1);
        mx = '{1, 2, 3, 4};
        run_vec(IN_LEN, 1'b1, 1'b0, 1'b0);

        // Random coefficients and inputs; odd rounds also hammer writes while busy
        for (int r = 0; r < 10; r++) begin
            int len;
            for (int o = 0; o < N_OUT; o++) begin
                mb[o] = shortint'($urandom);
                for (int i = 0; i < IN_LEN; i++)
                    mw[o][i] = (r < 5) ? shortint'(int'($urandom_range(0, 200)) - 100)
                                       : shortint'($urandom);
            end
            for (int i = 0; i < IN_LEN; i++)
                mx[i] = (r < 5) ? int'($urandom_range(0, 2000)) - 1000 : int'($urandom);
            load_wts();
            len = (r % 3 == 2) ? int'($urandom_range(1, IN_LEN-1)) : IN_LEN;
            run_vec(len, (len < IN_LEN) ? 1'b1 : 1'(r % 2), 1'(r % 2), 1'b0);
            // Same vector again: any write that slipped through while busy shows up here
            if (r % 2 == 1)
                run_vec(len, 1'b1, 1'b0, 1'b0);
        end

        // Default-size instance
        for (int a = 0; a < B_OUT*B_LEN + B_OUT; a++) begin
            b_wen   = 1'b1;
            b_waddr = B_AW'(a);
            b_wdata = (a < B_OUT*B_LEN) ? 16'd1 : 16'd0;
            @(posedge clk); #1;
        end
        b_wen = 1'b0;
        big_run(1'b1);
        big_run(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
